// File: rtl/onehot_seq_pkg.sv
// Shared constants and helpers for the one-hot schedule sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Exports: DEFAULT_NUM_STATES, DEFAULT_CNT_W, MAX_STATES,
//          state_bit(idx), is_onehot0(vec).
package onehot_seq_pkg;

    localparam int DEFAULT_NUM_STATES = 15;
    localparam int DEFAULT_CNT_W      = 16;

    // Helpers work on a fixed wide vector; NUM_STATES must not exceed this.
    localparam int MAX_STATES = 64;

    // One-hot constant for state (idx+1); same encoding as the datapath's
    // fsm_stateNN parameters.
    function automatic logic [MAX_STATES-1:0] state_bit(input int unsigned idx);
        return MAX_STATES'(1) << idx;
    endfunction

    // True for the all-zero vector or a vector with exactly one bit set.
    function automatic logic is_onehot0(input logic [MAX_STATES-1:0] vec);
        return (vec & (vec - MAX_STATES'(1))) == '0;
    endfunction

endpackage

// File: rtl/onehot_seq_check.sv
// Sticky one-hot integrity checker for the sequencer state vector.
// Latency: bad is combinational; err rises on the edge after a bad vector.
// Backpressure: none; observes state only.
// Ports: clk, reset (sync, active-high), state (in), bad (comb flag), err (sticky).
module onehot_seq_check
    import onehot_seq_pkg::*;
#(
    parameter int NUM_STATES = DEFAULT_NUM_STATES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STATES-1:0] state,
    output logic                  bad,
    output logic                  err
);

    assign bad = !is_onehot0(MAX_STATES'(state));

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bad) begin
            err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!bad)
                else $error("onehot_seq_check: state vector %0h is not zero/one-hot", state);
        end
    end
`endif

endmodule

// File: rtl/onehot_seq_driver.sv
// Start/done handshaked, stallable one-hot state sequencer for a scheduled datapath.
// Latency: start -> state01 in 1 cycle; unstalled run busy NUM_STATES cycles, done 1 cycle after final state.
// Backpressure: stall holds the current state; abort returns to idle; start ignored mid-run.
// Ports: clk, reset (sync, active-high), start, stall, abort (in);
//        state (one-hot, 0 = idle), busy, done (1-cycle pulse), run_count (wrapping).
// Optional: define ONEHOT_SEQ_CHECK_EN to add the sticky err output and
//           force idle whenever state is neither zero nor one-hot.
module onehot_seq_driver
    import onehot_seq_pkg::*;
#(
    parameter int NUM_STATES = DEFAULT_NUM_STATES,  // 2..MAX_STATES
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  abort,
    output logic [NUM_STATES-1:0] state,
    output logic                  busy,
    output logic                  done,
`ifdef ONEHOT_SEQ_CHECK_EN
    output logic                  err,
`endif
    output logic [CNT_W-1:0]      run_count
);

    localparam logic [MAX_STATES-1:0] FIRST_W = state_bit(0);
    localparam logic [NUM_STATES-1:0] FIRST   = FIRST_W[NUM_STATES-1:0];

    logic [NUM_STATES-1:0] state_q, state_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last;
    logic                  bad;

`ifdef ONEHOT_SEQ_CHECK_EN
    onehot_seq_check #(
        .NUM_STATES (NUM_STATES)
    ) u_check (
        .clk   (clk),
        .reset (reset),
        .state (state_q),
        .bad   (bad),
        .err   (err)
    );
`else
    assign bad = 1'b0;
`endif

    assign last = state_q[NUM_STATES-1];

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (state_q == '0) begin
            // abort beats a simultaneous start while idle
            if (start && !abort) begin
                state_d = FIRST;
            end
        end else if (abort) begin
            state_d = '0;
        end else if (!stall) begin
            if (last) begin
                done_d  = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // start on the final cycle chains the next run with no bubble
                state_d = start ? FIRST : '0;
            end else begin
                state_d = state_q << 1;
            end
        end
        // A corrupted vector is discarded outright: no done, no count.
        if (bad) begin
            state_d = '0;
            done_d  = 1'b0;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state     = state_q;
    assign busy      = |state_q;
    assign done      = done_q;
    assign run_count = cnt_q;

endmodule

// File: tb/tb_onehot_seq_driver.sv
// Directed self-checking bench for onehot_seq_driver (NUM_STATES=15, CNT_W=16).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_onehot_seq_driver;

    localparam int NS = 15;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stall;
    logic          abort;
    logic [NS-1:0] state;
    logic          busy;
    logic          done;
    logic [CW-1:0] run_count;
`ifdef ONEHOT_SEQ_CHECK_EN
    logic          err;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    onehot_seq_driver #(
        .NUM_STATES (NS),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .abort     (abort),
        .state     (state),
        .busy      (busy),
        .done      (done),
`ifdef ONEHOT_SEQ_CHECK_EN
        .err       (err),
`endif
        .run_count (run_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full output set against expected state/done/count.
    task automatic chk_all(input string tag, input logic [31:0] exp_state,
                           input logic exp_done, input logic [31:0] exp_cnt);
        chk({tag, "_state"}, 32'(state), exp_state);
        chk({tag, "_busy"}, 32'(busy), 32'(exp_state != 0));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_cnt"}, 32'(run_count), exp_cnt);
    endtask

    initial begin
        int busy_cycles;
        int edges;
        logic [31:0] base;

        reset = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;

        // ---- reset then idle ----
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("rst", 0, 1'b0, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("idle", 0, 1'b0, 0);
        end

        // ---- single unstalled run ----
        start = 1'b1;
        busy_cycles = 0;
        tick();
        start = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (k > 0) tick();
            chk_all("run", 32'(1) << k, 1'b0, 0);
            if (busy) busy_cycles++;
        end
        tick();
        chk_all("run_end", 0, 1'b1, 1);
        tick();
        chk_all("run_after", 0, 1'b0, 1);
        chk("run_busy_cycles", 32'(busy_cycles), 32'(NS));

        // ---- stall at 0x0008 for 3 cycles ----
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        tick(); tick(); tick();
        edges += 3;
        chk("stall_pre", 32'(state), 32'h0008);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            edges++;
            chk("stall_hold", 32'(state), 32'h0008);
        end
        stall = 1'b0;
        tick();
        edges++;
        chk("stall_release", 32'(state), 32'h0010);
        while (!done && edges < 100) begin
            tick();
            edges++;
        end
        // unstalled run: done on the 16th edge counting the start edge
        chk("stall_done_edge", 32'(edges), 32'(NS + 1 + 3));
        chk("stall_cnt", 32'(run_count), 2);

        // ---- stall on the final state, start ignored while stalled ----
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < NS; k++) tick();
        chk("fstall_pre", 32'(state), 32'h4000);
        stall = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_all("fstall_hold", 32'h4000, 1'b0, 2);
        end
        stall = 1'b0;
        start = 1'b0;
        tick();
        chk_all("fstall_end", 0, 1'b1, 3);

        // ---- back-to-back runs with start held high ----
        base = 32'(run_count);
        start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NS; k++) begin
                tick();
                chk_all("b2b", 32'(1) << k, (r > 0 && k == 0), base + 32'(r));
            end
        end
        start = 1'b0;
        tick();
        chk_all("b2b_end", 0, 1'b1, base + 3);

        // ---- abort at 0x0100, start mid-run ignored ----
        base = 32'(run_count);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1;          // mid-run start must not restart
        tick();
        start = 1'b0;
        chk("busy_start_ign", 32'(state), 32'h0008);
        for (int k = 4; k < 9; k++) tick();
        chk("abort_pre", 32'(state), 32'h0100);
        abort = 1'b1;
        tick();
        chk_all("abort", 0, 1'b0, base);
        // abort with start while idle: stay idle
        start = 1'b1;
        tick();
        chk_all("abort_idle", 0, 1'b0, base);
        abort = 1'b0;
        start = 1'b0;

        // ---- reset mid-run at 0x0020 ----
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 6; k++) tick();
        chk("rstmid_pre", 32'(state), 32'h0020);
        reset = 1'b1;
        tick();
        chk_all("rstmid", 0, 1'b0, 0);
        reset = 1'b0;
        tick();
        chk_all("rstmid_after", 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
